global_mem_pe_responder: RTL and testbench

// - Global-memory side of one PE's ld/st channels. Responder for ld_global_mem_addr_req/gnt/data_vld and st_global_mem_st_req/gnt.
// - Arbitrates PE loads, PE stores and host init accesses onto one single-port SRAM (sp_mem_model, fixed read latency).
// - Returns load data in order.

---
 rtl/global_mem_pe_responder.sv | 128 ++++++++++++
 tb/tb_global_mem_pe_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/global_mem_pe_responder.sv
// rtl/global_mem_pe_responder.sv - global-memory responder for one PE's ld/st channels plus host init port
// Optional statistics counters enabled by GLOBAL_MEM_STATS_EN.
module global_mem_pe_responder #(
   parameter int DATA_L            = 32,
   parameter int GLOBAL_MEM_ADDR_L = 16,
   parameter int RD_LATENCY        = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [GLOBAL_MEM_ADDR_L-1:0] ld_global_mem_addr,
   input  logic                         ld_global_mem_addr_req,
   output logic                         ld_global_mem_addr_gnt,
   output logic [DATA_L-1:0]            ld_global_mem_data,
   output logic                         ld_global_mem_data_vld,
   input  logic [GLOBAL_MEM_ADDR_L-1:0] st_global_mem_addr,
   input  logic [DATA_L-1:0]            st_global_mem_data,
   input  logic                         st_global_mem_st_req,
   output logic                         st_global_mem_st_gnt,
   input  logic [GLOBAL_MEM_ADDR_L-1:0] init_mem_addr,
   input  logic [DATA_L-1:0]            init_mem_wr_data,
   input  logic                         init_mem_vld,
   input  logic                         init_mem_wr_en,
   output logic [DATA_L-1:0]            init_mem_rd_data,
   output logic                         init_mem_rd_data_vld,
   output logic [GLOBAL_MEM_ADDR_L-1:0] mem_addr,
   output logic [DATA_L-1:0]            mem_wr_data,
   output logic                         mem_wr_en,
   output logic                         mem_ch_en,
   input  logic [DATA_L-1:0]            mem_rd_data,
   output logic [31:0]                  stat_ld_cnt,
   output logic [31:0]                  stat_st_cnt,
   output logic [31:0]                  stat_conflict_cnt
);

   logic                  rr_st_next;
   logic                  init_sel;
   logic                  ld_win;
   logic                  st_win;
   logic                  rr_toggle;
   logic                  rd_issue;
   logic [RD_LATENCY-1:0] vld_sr;
   logic [RD_LATENCY-1:0] init_sr;

   // Host always wins; ld/st contention resolved by the round-robin flag.
   always_comb begin
      init_sel  = 1'b0;
      ld_win    = 1'b0;
      st_win    = 1'b0;
      rr_toggle = 1'b0;
      if (!rst) begin
         if (init_mem_vld) begin
            init_sel = 1'b1;
         end else if (ld_global_mem_addr_req && st_global_mem_st_req) begin
            rr_toggle = 1'b1;
            if (rr_st_next) st_win = 1'b1;
            else            ld_win = 1'b1;
         end else if (ld_global_mem_addr_req) begin
            ld_win = 1'b1;
         end else if (st_global_mem_st_req) begin
            st_win = 1'b1;
         end
      end
   end

   always_comb begin
      mem_ch_en   = init_sel | ld_win | st_win;
      mem_wr_en   = st_win | (init_sel & init_mem_wr_en);
      mem_addr    = '0;
      mem_wr_data = '0;
      if (init_sel) begin
         mem_addr    = init_mem_addr;
         mem_wr_data = init_mem_wr_data;
      end else if (ld_win) begin
         mem_addr    = ld_global_mem_addr;
      end else if (st_win) begin
         mem_addr    = st_global_mem_addr;
         mem_wr_data = st_global_mem_data;
      end
   end

   assign ld_global_mem_addr_gnt = ld_win;
   assign st_global_mem_st_gnt   = st_win;
   assign rd_issue               = ld_win | (init_sel & ~init_mem_wr_en);

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_st_next <= 1'b0;
         vld_sr     <= '0;
         init_sr    <= '0;
      end else begin
         if (rr_toggle) rr_st_next <= ~rr_st_next;
         vld_sr[0]  <= rd_issue;
         init_sr[0] <= init_sel;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld_sr[i]  <= vld_sr[i-1];
            init_sr[i] <= init_sr[i-1];
         end
      end
   end

   // SRAM data passes straight through; the tail of the tracker says who owns it.
   assign ld_global_mem_data     = mem_rd_data;
   assign init_mem_rd_data       = mem_rd_data;
   assign ld_global_mem_data_vld = ~rst & vld_sr[RD_LATENCY-1] & ~init_sr[RD_LATENCY-1];
   assign init_mem_rd_data_vld   = ~rst & vld_sr[RD_LATENCY-1] & init_sr[RD_LATENCY-1];

`ifdef GLOBAL_MEM_STATS_EN
   logic conflict;
   assign conflict = (ld_global_mem_addr_req & ~ld_win) | (st_global_mem_st_req & ~st_win);

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_ld_cnt       <= '0;
         stat_st_cnt       <= '0;
         stat_conflict_cnt <= '0;
      end else begin
         if (ld_win)   stat_ld_cnt       <= stat_ld_cnt + 32'd1;
         if (st_win)   stat_st_cnt       <= stat_st_cnt + 32'd1;
         if (conflict) stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
      end
   end
`else
   assign stat_ld_cnt       = '0;
   assign stat_st_cnt       = '0;
   assign stat_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_global_mem_pe_responder.sv
// tb/tb_global_mem_pe_responder.sv - directed scoreboard bench for global_mem_pe_responder
module tb_global_mem_pe_responder;

   localparam int RDL = 2;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] ld_addr;
   logic        ld_req;
   logic        ld_gnt;
   logic [31:0] ld_data;
   logic        ld_vld;
   logic [15:0] st_addr;
   logic [31:0] st_data;
   logic        st_req;
   logic        st_gnt;
   logic [15:0] init_addr;
   logic [31:0] init_wdata;
   logic        init_vld;
   logic        init_wr_en;
   logic [31:0] init_rdata;
   logic        init_rvld;
   logic [15:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic        mem_wr_en;
   logic        mem_ch_en;
   logic [31:0] mem_rd_data;
   logic [31:0] stat_ld_cnt;
   logic [31:0] stat_st_cnt;
   logic [31:0] stat_conflict_cnt;

   logic [31:0] sram [256] = '{default: '0};
   logic [31:0] ref_mem [256] = '{default: '0};
   logic [31:0] rd_s1 = '0;
   logic [31:0] rd_s2 = '0;

   exp_t ld_q[$];
   exp_t init_q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   drop = 1'b0;

   global_mem_pe_responder #(.DATA_L(32), .GLOBAL_MEM_ADDR_L(16), .RD_LATENCY(RDL)) dut (
      .clk(clk), .rst(rst),
      .ld_global_mem_addr(ld_addr), .ld_global_mem_addr_req(ld_req),
      .ld_global_mem_addr_gnt(ld_gnt), .ld_global_mem_data(ld_data),
      .ld_global_mem_data_vld(ld_vld),
      .st_global_mem_addr(st_addr), .st_global_mem_data(st_data),
      .st_global_mem_st_req(st_req), .st_global_mem_st_gnt(st_gnt),
      .init_mem_addr(init_addr), .init_mem_wr_data(init_wdata),
      .init_mem_vld(init_vld), .init_mem_wr_en(init_wr_en),
      .init_mem_rd_data(init_rdata), .init_mem_rd_data_vld(init_rvld),
      .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
      .mem_ch_en(mem_ch_en), .mem_rd_data(mem_rd_data),
      .stat_ld_cnt(stat_ld_cnt), .stat_st_cnt(stat_st_cnt),
      .stat_conflict_cnt(stat_conflict_cnt)
   );

   always #5 clk = ~clk;

   // Single-port SRAM with a two-cycle read pipeline.
   always @(posedge clk) begin
      if (mem_ch_en) begin
         if (mem_wr_en) sram[mem_addr[7:0]] <= mem_wr_data;
         else           rd_s1 <= sram[mem_addr[7:0]];
      end
      rd_s2 <= rd_s1;
   end
   assign mem_rd_data = rd_s2;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      if (ld_vld) begin
         if (ld_q.size() == 0) chk("ld_vld_unexpected", 32'd1, 32'd0);
         else begin
            mon_e = ld_q.pop_front();
            chk("ld_data", ld_data, mon_e.data);
            chk("ld_time", cyc, mon_e.due);
         end
      end
      if (ld_q.size() > 0 && ld_q[0].due < cyc) begin
         chk("ld_vld_missing", 32'd0, 32'd1);
         void'(ld_q.pop_front());
      end
      if (init_rvld) begin
         if (init_q.size() == 0) chk("init_vld_unexpected", 32'd1, 32'd0);
         else begin
            mon_e = init_q.pop_front();
            chk("init_data", init_rdata, mon_e.data);
            chk("init_time", cyc, mon_e.due);
         end
      end
      if (init_q.size() > 0 && init_q[0].due < cyc) begin
         chk("init_vld_missing", 32'd0, 32'd1);
         void'(init_q.pop_front());
      end
   end

   task automatic step(input logic eg_ld, input logic eg_st);
      exp_t e;
      @(negedge clk);
      chk("ld_gnt", ld_gnt, eg_ld);
      chk("st_gnt", st_gnt, eg_st);
      if (eg_ld && !drop) begin
         e.data = ref_mem[ld_addr[7:0]];
         e.due  = cyc + RDL;
         ld_q.push_back(e);
      end
      if (eg_st) ref_mem[st_addr[7:0]] = st_data;
      if (init_vld && !rst) begin
         if (init_wr_en) ref_mem[init_addr[7:0]] = init_wdata;
         else begin
            e.data = ref_mem[init_addr[7:0]];
            e.due  = cyc + RDL;
            init_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ld_req   = 1'b0;
      st_req   = 1'b0;
      init_vld = 1'b0;
   endtask

   task automatic init_wr(input logic [15:0] a, input logic [31:0] d);
      init_vld = 1'b1; init_wr_en = 1'b1; init_addr = a; init_wdata = d;
      step(1'b0, 1'b0);
      init_vld = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      ld_addr = '0; st_addr = '0; st_data = '0;
      init_addr = '0; init_wdata = '0; init_wr_en = 1'b0;
      ld_req = 1'b1; st_req = 1'b1; init_vld = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_ld_gnt", ld_gnt, 1'b0);
      chk("rst_st_gnt", st_gnt, 1'b0);
      chk("rst_mem_ch_en", mem_ch_en, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_ld_vld", ld_vld, 1'b0);
      @(posedge clk); #1;
      idle();
      rst = 1'b0;

      // Round-robin from reset: both requests held four cycles.
      ld_req = 1'b1; ld_addr = 16'h0000;
      st_req = 1'b1; st_addr = 16'h0020; st_data = 32'h1234;
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      idle();
      @(negedge clk);
`ifdef GLOBAL_MEM_STATS_EN
      chk("stat_ld_cnt", stat_ld_cnt, 32'd2);
      chk("stat_st_cnt", stat_st_cnt, 32'd2);
      chk("stat_conflict_cnt", stat_conflict_cnt, 32'd4);
`else
      chk("stat_ld_cnt_off", stat_ld_cnt, 32'd0);
      chk("stat_st_cnt_off", stat_st_cnt, 32'd0);
      chk("stat_conflict_cnt_off", stat_conflict_cnt, 32'd0);
`endif
      chk("idle_mem_ch_en", mem_ch_en, 1'b0);
      chk("idle_mem_wr_data", mem_wr_data, 32'd0);
      @(posedge clk); #1;

      // Preload through the host port.
      init_wr(16'h0010, 32'h000000A0);
      init_wr(16'h0011, 32'h000000A1);
      init_wr(16'h0012, 32'h000000A2);
      init_vld = 1'b1; init_wr_en = 1'b1; init_addr = 16'h0007; init_wdata = 32'h77;
      @(negedge clk);
      chk("init_mem_wr_en", mem_wr_en, 1'b1);
      chk("init_mem_addr", mem_addr, 32'h7);
      @(posedge clk); #1;
      ref_mem[7] = 32'h77;
      init_vld = 1'b0;

      // Back-to-back loads.
      ld_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ld_addr = 16'h0010 + 16'(i);
         step(1'b1, 1'b0);
      end
      idle();
      repeat (3) step(1'b0, 1'b0);

      // Store then load to the same address.
      st_req = 1'b1; st_addr = 16'h0005; st_data = 32'h0000DEAD;
      step(1'b0, 1'b1);
      st_req = 1'b0; ld_req = 1'b1; ld_addr = 16'h0005;
      step(1'b1, 1'b0);
      idle();
      repeat (3) step(1'b0, 1'b0);

      // Host read beats a concurrent PE load; the load follows next cycle.
      init_vld = 1'b1; init_wr_en = 1'b0; init_addr = 16'h0007;
      ld_req = 1'b1; ld_addr = 16'h0011;
      step(1'b0, 1'b0);
      init_vld = 1'b0;
      step(1'b1, 1'b0);
      idle();
      repeat (3) step(1'b0, 1'b0);

      // Reset mid-flight: the granted load is dropped and the flag returns to 0.
      ld_req = 1'b1; ld_addr = 16'h0010;
      st_req = 1'b1; st_addr = 16'h0030; st_data = 32'h55;
      drop = 1'b1;
      step(1'b1, 1'b0);
      drop = 1'b0;
      rst = 1'b1;
      step(1'b0, 1'b0);
      rst = 1'b0;
      step(1'b1, 1'b0);
      idle();
      repeat (4) step(1'b0, 1'b0);

      chk("ld_q_drained", ld_q.size(), 32'd0);
      chk("init_q_drained", init_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
